pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Merges the forwarding unit's load-use hazard with three other stall sources:
  - taken-branch redirect from EX
  - multi-cycle MUL/DIV unit in EX (start/done handshake)
  - data-memory wait in MEM, guarded by a timeout watchdog
- Drives the per-stage stall/flush vectors and counts stall cycles for performance monitoring.

Parameters:
- TIMEOUT, 16: max stalled cycles for an unacked data-memory request before a bus error; must be >= 2.
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- load_hazard_i  in  1  load-use hazard from forwarding unit (ID depends on load in EX)
- branch_taken_i  in  1  taken branch/jump resolved in EX
- md_req_i  in  1  EX holds a MUL/DIV op
- md_done_i  in  1  MUL/DIV result valid (1-cycle pulse)
- dmem_req_i  in  1  MEM stage issuing load/store
- dmem_ack_i  in  1  data memory completes access this cycle
- stall_o  out  5  hold stage register; bit 0=PC, 1=IF_ID, 2=ID_EX, 3=EX_MEM, 4=MEM_WB
- flush_o  out  5  insert bubble into stage register, same bit map
- md_start_o  out  1  1-cycle start pulse to MUL/DIV unit
- bus_err_o  out  1  1-cycle data-memory timeout pulse
- state_o  out  2  current FSM state (debug)
- stall_cycles_o  out  CNT_W  count of cycles with any stall_o bit set

Behaviour:
- Outputs stall_o, flush_o, md_start_o and bus_err_o are combinational from state plus inputs. State, wait_cnt and stall_cycles are registered.
- Reset (rst_i=1, asynchronous):
  - state=RUN, wait_cnt=0, stall_cycles_o=0.
  - stall_o, flush_o, md_start_o and bus_err_o forced to 0 while rst_i is high.
  - Reset mid-MD_WAIT or mid-MEM_WAIT abandons the operation; the MUL/DIV unit shares rst_i.
- States: RUN=0, MD_WAIT=1, MEM_WAIT=2. Encoding 3 is unreachable and recovers to RUN next cycle with outputs 0.
- RUN, first match wins:
  1. dmem_req_i & !dmem_ack_i: stall=5'b01111, flush=5'b10000. Next state MEM_WAIT, wait_cnt<=1.
  2. md_req_i: md_start_o=1, stall=5'b00111, flush=5'b01000. Next state MD_WAIT.
  3. branch_taken_i: stall=0, flush=5'b00110. Load hazard is ignored because the dependent instruction is squashed.
  4. load_hazard_i: stall=5'b00011, flush=5'b00100.
  5. Otherwise all outputs are 0.
- MD_WAIT:
  - Each cycle without done: stall=5'b00111, flush=5'b01000.
  - md_done_i=1: stall=0, flush=0 (result advances), next state RUN.
  - load_hazard_i and branch_taken_i are ignored; md_req_i stays high and is not re-sampled.
  - md_done_i is ignored outside MD_WAIT. Done arrives no earlier than the cycle after md_start_o.
  - If dmem_req_i & !dmem_ack_i occurs in MD_WAIT, the dmem pattern is applied that cycle with no state change.
- MEM_WAIT:
  - dmem_ack_i=1: stall=0, flush=0, next state RUN, wait_cnt<=0. Ack wins over timeout in the same cycle.
  - Else if wait_cnt==TIMEOUT: bus_err_o=1, stall=0, flush=5'b11110, next state RUN, wait_cnt<=0.
  - Else: stall=5'b01111, flush=5'b10000, wait_cnt<=wait_cnt+1.
  - All other inputs are ignored.
- Timeout timing: a request first unacked at cycle N stalls cycles N..N+TIMEOUT-1 (TIMEOUT cycles) and bus_err_o fires at N+TIMEOUT.
- wait_cnt width is $clog2(TIMEOUT+1).
- stall_cycles_o increments in any cycle with |stall_o. It wraps from 2^CNT_W-1 to 0 without saturation.

Decomposition:
- Shared package holds:
  - stage bit indices STG_PC=0, STG_IF_ID=1, STG_ID_EX=2, STG_EX_MEM=3, STG_MEM_WB=4
  - FSM state encodings
  - the 5-bit stall/flush patterns named above
- One sub-module, perf_counter: CNT_W-bit enable counter with async reset, wrap-around.

Test Plan:
- Reset: assert rst_i mid-MEM_WAIT with wait_cnt=3 -> stall_o=flush_o=0 immediately, state_o=0, stall_cycles_o=0.
- Load hazard: load_hazard_i=1 for one cycle in RUN -> stall_o=5'b00011, flush_o=5'b00100 for that cycle only, stall_cycles_o +1.
- Branch vs hazard: branch_taken_i=1 and load_hazard_i=1 together -> stall_o=0, flush_o=5'b00110.
- MUL/DIV: md_req_i=1, md_done_i 3 cycles after start -> md_start_o one pulse, 3 stall cycles of 5'b00111 plus a release cycle with stall_o=0, stall_cycles_o +3.
- Data-memory ack: TIMEOUT=4, request unacked then ack at cycle N+4 -> stalls N..N+3, release at N+4, bus_err_o stays 0.
- Data-memory timeout: TIMEOUT=4, no ack -> stalls N..N+3, at N+4 bus_err_o=1 and flush_o=5'b11110, state_o=0 at N+5.
- Counter wrap: CNT_W=4, 17 stall cycles -> stall_cycles_o=1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stage bit map,
// FSM encodings and the per-hazard stall/flush patterns.
package pipeline_ctrl_pkg;

  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_BAD      = 2'd3
  } state_e;

  localparam logic [4:0] PAT_NONE      = 5'b00000;
  localparam logic [4:0] PAT_MEM_STALL = 5'b01111;
  localparam logic [4:0] PAT_MEM_FLUSH = 5'b10000;
  localparam logic [4:0] PAT_MD_STALL  = 5'b00111;
  localparam logic [4:0] PAT_MD_FLUSH  = 5'b01000;
  localparam logic [4:0] PAT_BR_FLUSH  = 5'b00110;
  localparam logic [4:0] PAT_LH_STALL  = 5'b00011;
  localparam logic [4:0] PAT_LH_FLUSH  = 5'b00100;
  localparam logic [4:0] PAT_TO_FLUSH  = 5'b11110;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush outputs between the pipeline and its sequencer.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             load_hazard_i;
  logic             branch_taken_i;
  logic             md_req_i;
  logic             md_done_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic [4:0]       stall_o;
  logic [4:0]       flush_o;
  logic             md_start_o;
  logic             bus_err_o;
  state_e           state_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport slave (
    input  load_hazard_i, branch_taken_i, md_req_i, md_done_i, dmem_req_i, dmem_ack_i,
    output stall_o, flush_o, md_start_o, bus_err_o, state_o, stall_cycles_o
  );

  modport master (
    output load_hazard_i, branch_taken_i, md_req_i, md_done_i, dmem_req_i, dmem_ack_i,
    input  stall_o, flush_o, md_start_o, bus_err_o, state_o, stall_cycles_o
  );
endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running enable counter for performance monitoring; wraps without saturation.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] r_count;

  // count enabled cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count_o = r_count;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: merges load-use, branch,
// MUL/DIV and data-memory wait hazards, with a memory timeout watchdog.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipeline_ctrl_if.slave  bus
);
  localparam int              WC_W   = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  state_e           r_state;
  state_e           w_next_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_next_wait_cnt;
  logic [4:0]       w_stall;
  logic [4:0]       w_flush;
  logic             w_md_start;
  logic             w_bus_err;
  logic             w_mem_miss;
  logic [CNT_W-1:0] w_stall_cycles;

  assign w_mem_miss = bus.dmem_req_i & ~bus.dmem_ack_i;

  // state and watchdog registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // next-state and hazard pattern selection
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_stall         = PAT_NONE;
    w_flush         = PAT_NONE;
    w_md_start      = 1'b0;
    w_bus_err       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_miss) begin
          w_stall         = PAT_MEM_STALL;
          w_flush         = PAT_MEM_FLUSH;
          w_next_state    = ST_MEM_WAIT;
          w_next_wait_cnt = WC_W'(1);
        end else if (bus.md_req_i) begin
          w_md_start   = 1'b1;
          w_stall      = PAT_MD_STALL;
          w_flush      = PAT_MD_FLUSH;
          w_next_state = ST_MD_WAIT;
        end else if (bus.branch_taken_i) begin
          // the load-use dependent instruction is squashed by the redirect
          w_flush = PAT_BR_FLUSH;
        end else if (bus.load_hazard_i) begin
          w_stall = PAT_LH_STALL;
          w_flush = PAT_LH_FLUSH;
        end else begin
          w_stall = PAT_NONE;
        end
      end
      ST_MD_WAIT: begin
        if (bus.md_done_i) begin
          w_next_state = ST_RUN;
        end else if (w_mem_miss) begin
          w_stall = PAT_MEM_STALL;
          w_flush = PAT_MEM_FLUSH;
        end else begin
          w_stall = PAT_MD_STALL;
          w_flush = PAT_MD_FLUSH;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          w_next_state    = ST_RUN;
          w_next_wait_cnt = '0;
        end else if (r_wait_cnt == WC_MAX) begin
          w_bus_err       = 1'b1;
          w_flush         = PAT_TO_FLUSH;
          w_next_state    = ST_RUN;
          w_next_wait_cnt = '0;
        end else begin
          w_stall         = PAT_MEM_STALL;
          w_flush         = PAT_MEM_FLUSH;
          w_next_wait_cnt = r_wait_cnt + WC_W'(1);
        end
      end
      default: begin
        w_next_state    = ST_RUN;
        w_next_wait_cnt = '0;
      end
    endcase
  end

  assign bus.stall_o        = rst_i ? PAT_NONE : w_stall;
  assign bus.flush_o        = rst_i ? PAT_NONE : w_flush;
  assign bus.md_start_o     = rst_i ? 1'b0 : w_md_start;
  assign bus.bus_err_o      = rst_i ? 1'b0 : w_bus_err;
  assign bus.state_o        = r_state;
  assign bus.stall_cycles_o = w_stall_cycles;

  perf_counter #(
    .CNT_W (CNT_W)
  ) u_perf_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (|bus.stall_o),
    .count_o (w_stall_cycles)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + randomized bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_vec = 0;
  int   n_err = 0;

  // model: mode 0=running, 1=waiting on MUL/DIV, 2=waiting on memory
  int   m_mode;
  int   m_waited;
  int   m_cnt;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_waited = 0;
    m_cnt    = 0;
  endtask

  // one clock cycle: drive after negedge, check combinational outputs, advance model
  task automatic step(input bit lh, input bit br, input bit mr, input bit md,
                      input bit dr, input bit da);
    logic [4:0] e_stall;
    logic [4:0] e_flush;
    bit         e_start;
    bit         e_err;
    bit         miss;
    int         nxt_mode;
    @(negedge clk_i);
    bus.load_hazard_i  = lh;
    bus.branch_taken_i = br;
    bus.md_req_i       = mr;
    bus.md_done_i      = md;
    bus.dmem_req_i     = dr;
    bus.dmem_ack_i     = da;
    #1;
    e_stall  = 5'b00000;
    e_flush  = 5'b00000;
    e_start  = 1'b0;
    e_err    = 1'b0;
    miss     = dr && !da;
    nxt_mode = m_mode;
    if (m_mode == 0) begin
      if (miss) begin
        e_stall = 5'b01111; e_flush = 5'b10000; nxt_mode = 2; m_waited = 1;
      end else if (mr) begin
        e_start = 1'b1; e_stall = 5'b00111; e_flush = 5'b01000; nxt_mode = 1;
      end else if (br) begin
        e_flush = 5'b00110;
      end else if (lh) begin
        e_stall = 5'b00011; e_flush = 5'b00100;
      end
    end else if (m_mode == 1) begin
      if (md) nxt_mode = 0;
      else if (miss) begin e_stall = 5'b01111; e_flush = 5'b10000; end
      else begin e_stall = 5'b00111; e_flush = 5'b01000; end
    end else begin
      if (da) begin
        nxt_mode = 0; m_waited = 0;
      end else if (m_waited == TIMEOUT) begin
        e_err = 1'b1; e_flush = 5'b11110; nxt_mode = 0; m_waited = 0;
      end else begin
        e_stall = 5'b01111; e_flush = 5'b10000; m_waited++;
      end
    end
    chk("stall",    32'(bus.stall_o),        32'(e_stall));
    chk("flush",    32'(bus.flush_o),        32'(e_flush));
    chk("md_start", 32'(bus.md_start_o),     32'(e_start));
    chk("bus_err",  32'(bus.bus_err_o),      32'(e_err));
    chk("state",    32'(bus.state_o),        32'(m_mode));
    chk("count",    32'(bus.stall_cycles_o), 32'(m_cnt));
    if (e_stall != 5'b00000) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_mode = nxt_mode;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.load_hazard_i = 1'b0; bus.branch_taken_i = 1'b0; bus.md_req_i = 1'b0;
    bus.md_done_i = 1'b0; bus.dmem_req_i = 1'b0; bus.dmem_ack_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    bit lh, br, mr, md, dr, da;
    rst_i = 1'b1;
    model_reset();
    do_reset();
    step(0, 0, 0, 0, 0, 0);

    // asynchronous reset three cycles into a memory wait
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_stall", 32'(bus.stall_o),        32'd0);
    chk("rst_flush", 32'(bus.flush_o),        32'd0);
    chk("rst_state", 32'(bus.state_o),        32'd0);
    chk("rst_count", 32'(bus.stall_cycles_o), 32'd0);
    chk("rst_err",   32'(bus.bus_err_o),      32'd0);
    do_reset();

    // load hazard, branch beating hazard, idle
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("br_flush", 32'(bus.flush_o), 32'h06);

    // MUL/DIV with done three cycles after start
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("md_release", 32'(bus.stall_o), 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // memory ack exactly at the timeout boundary
    for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("ack_err", 32'(bus.bus_err_o), 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // memory timeout
    for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("tmo_err",   32'(bus.bus_err_o), 32'd1);
    chk("tmo_flush", 32'(bus.flush_o),   32'h1E);
    step(0, 0, 0, 0, 0, 0);

    // counter wrap: 17 stalled cycles on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap", 32'(bus.stall_cycles_o), 32'd1);

    // randomized traffic honouring the MUL/DIV and memory handshakes
    for (int i = 0; i < 400; i++) begin
      lh = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 3) == 0);
      if (m_mode == 1) begin
        mr = 1'b1;
        md = 1'($urandom_range(0, 2) == 0);
        dr = md ? 1'b0 : 1'($urandom_range(0, 3) == 0);
        da = 1'($urandom_range(0, 1));
      end else if (m_mode == 2) begin
        mr = 1'($urandom_range(0, 1));
        md = 1'($urandom_range(0, 1));
        dr = 1'b1;
        da = 1'($urandom_range(0, 4) == 0);
      end else begin
        mr = 1'($urandom_range(0, 3) == 0);
        md = mr ? 1'b0 : 1'($urandom_range(0, 1));
        dr = 1'($urandom_range(0, 3) == 0);
        da = 1'($urandom_range(0, 1));
      end
      step(lh, br, mr, md, dr, da);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
